// File: rtl/inst_fetch_fifo_if.sv
// Fetch-to-decode handshake bundle for inst_fetch_fifo.
// The master side is the fetch stage and pipeline controller. The slave side is the FIFO.
interface inst_fetch_fifo_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          push_valid;
  logic [31:0]   push_pc;
  logic [31:0]   push_inst;
  logic          push_excp;
  logic          pop_ready;
  logic          pop_valid;
  logic [31:0]   pop_pc;
  logic [31:0]   pop_inst;
  logic          pop_excp;
  logic          stallreq_for_fifo;
  logic [CW-1:0] count;

  modport master (
    output flush, push_valid, push_pc, push_inst, push_excp, pop_ready,
    input  pop_valid, pop_pc, pop_inst, pop_excp, stallreq_for_fifo, count
  );

  modport slave (
    input  flush, push_valid, push_pc, push_inst, push_excp, pop_ready,
    output pop_valid, pop_pc, pop_inst, pop_excp, stallreq_for_fifo, count
  );
endinterface

// File: rtl/inst_fetch_fifo.sv
// Instruction fetch/decode decoupling FIFO with a registered almost-full stall request and flush.
// Defining INST_FIFO_BYPASS_EN lets a push into an empty FIFO appear on pop_* in the same cycle.
module inst_fetch_fifo #(
  parameter int DEPTH        = 8,
  parameter int AFULL_MARGIN = 2
) (
  input  logic            clk,
  input  logic            resetn,
  inst_fetch_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 65;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [EW-1:0] r_mem [DEPTH];
  logic          r_stall;
  logic          r_ovf;

  logic          w_empty;
  logic          w_full;
  logic          w_pop_fire;
  logic          w_push_acc;
  logic          w_bypass;
  logic          w_bypass_take;
  logic [PW-1:0] w_count;
  logic [PW-1:0] w_count_next;
  logic [EW-1:0] w_head;
  logic [EW-1:0] w_push_entry;

  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_count      = r_wr_ptr - r_rd_ptr;
  assign w_pop_fire   = ~w_empty & bus.pop_ready;
  assign w_push_entry = {bus.push_excp, bus.push_inst, bus.push_pc};
  assign w_head       = r_mem[r_rd_ptr[AW-1:0]];

`ifdef INST_FIFO_BYPASS_EN
  assign w_bypass      = w_empty & bus.push_valid & ~bus.flush;
  assign w_bypass_take = w_bypass & bus.pop_ready;
`else
  assign w_bypass      = 1'b0;
  assign w_bypass_take = 1'b0;
`endif

  // The slot being freed by a same-cycle pop can take the push, even when the FIFO is full.
  assign w_push_acc = bus.push_valid & (~w_full | w_pop_fire) & ~w_bypass_take;

  always_comb begin
    w_count_next = w_count;
    if (bus.flush) begin
      w_count_next = '0;
    end else begin
      w_count_next = w_count + PW'(w_push_acc) - PW'(w_pop_fire);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_stall  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_stall <= (w_count_next >= PW'(DEPTH - AFULL_MARGIN));
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
        if (bus.push_valid && w_full && !w_pop_fire) r_ovf <= 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push_acc && !bus.flush) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_push_entry;
    end
  end

  // Gating the head entry with empty keeps stale or uninitialised storage off the outputs.
  always_comb begin
    bus.pop_valid = ~w_empty | w_bypass;
    bus.pop_pc    = 32'h0;
    bus.pop_inst  = 32'h0;
    bus.pop_excp  = 1'b0;
    if (w_bypass) begin
      bus.pop_pc   = bus.push_pc;
      bus.pop_inst = bus.push_inst;
      bus.pop_excp = bus.push_excp;
    end else if (!w_empty) begin
      bus.pop_pc   = w_head[31:0];
      bus.pop_inst = w_head[63:32];
      bus.pop_excp = w_head[64];
    end
  end

  assign bus.count             = w_count;
  assign bus.stallreq_for_fifo = r_stall;

  cover property (@(posedge clk) r_ovf);
endmodule

// File: tb/tb_inst_fetch_fifo.sv
// Directed test of inst_fetch_fifo. A reference queue holds expected entries and is compared on every pop.
// The bypass check is compiled only when INST_FIFO_BYPASS_EN is defined.
module tb_inst_fetch_fifo;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
  } ent_t;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_errors;
  int   cnt;
  logic exp_stall;
  logic exp_ovf;
  ent_t sb[$];

  inst_fetch_fifo_if #(.DEPTH(8)) bus ();

  inst_fetch_fifo #(.DEPTH(8), .AFULL_MARGIN(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc, input logic [31:0] inst,
                       input logic excp, input logic pr, input logic fl);
    bus.push_valid = pv;
    bus.push_pc    = pc;
    bus.push_inst  = inst;
    bus.push_excp  = excp;
    bus.pop_ready  = pr;
    bus.flush      = fl;
  endtask

  // One clock cycle: check outputs at negedge, advance the model, and return at posedge+1.
  task automatic step();
    logic popf;
    logic pacc;
    logic byp;
    ent_t e;
    @(negedge clk);
`ifdef INST_FIFO_BYPASS_EN
    byp = (cnt == 0) && bus.push_valid && !bus.flush && resetn;
`else
    byp = 1'b0;
`endif
    chk("count", 64'(bus.count), 64'(cnt));
    chk("pop_valid", 64'(bus.pop_valid), 64'((cnt != 0) || byp));
    chk("stallreq", 64'(bus.stallreq_for_fifo), 64'(exp_stall));
    chk("ovf", 64'(dut.r_ovf), 64'(exp_ovf));
    if (cnt != 0) begin
      if (bus.pop_ready) begin
        e = sb.pop_front();
        chk("pop_pc", 64'(bus.pop_pc), 64'(e.pc));
        chk("pop_inst", 64'(bus.pop_inst), 64'(e.inst));
        chk("pop_excp", 64'(bus.pop_excp), 64'(e.excp));
        $display("pop  pc=0x%08h inst=0x%08h excp=%0d count=%0d", bus.pop_pc, bus.pop_inst,
                 bus.pop_excp, bus.count);
      end
    end else if (byp) begin
      chk("bypass_pc", 64'(bus.pop_pc), 64'(bus.push_pc));
      chk("bypass_inst", 64'(bus.pop_inst), 64'(bus.push_inst));
      $display("bypass pc=0x%08h ready=%0d", bus.pop_pc, bus.pop_ready);
    end else begin
      chk("empty_pc", 64'(bus.pop_pc), 64'h0);
      chk("empty_inst", 64'(bus.pop_inst), 64'h0);
    end

    if (!resetn) begin
      cnt = 0;
      sb.delete();
      exp_ovf = 1'b0;
    end else if (bus.flush) begin
      cnt = 0;
      sb.delete();
    end else begin
      popf = (cnt != 0) && bus.pop_ready;
      pacc = bus.push_valid && ((cnt < 8) || popf) && !(byp && bus.pop_ready);
      if (bus.push_valid && cnt == 8 && !popf) exp_ovf = 1'b1;
      if (pacc) begin
        e.pc = bus.push_pc;
        e.inst = bus.push_inst;
        e.excp = bus.push_excp;
        sb.push_back(e);
        $display("push pc=0x%08h inst=0x%08h excp=%0d", e.pc, e.inst, e.excp);
      end
      cnt = cnt + int'(pacc) - int'(popf);
    end
    exp_stall = resetn && (cnt >= 6);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cnt       = 0;
    exp_stall = 1'b0;
    exp_ovf   = 1'b0;
    resetn    = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    step();
    resetn = 1'b1;

    // Single push, then pop one cycle later
    drive(1'b1, 32'hBFC0_0000, 32'h3C1D_0000, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    step();

    // Fill to full; stall after the 6th push; a 9th push is dropped and sets ovf
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * i), 32'h5000 + 32'(i), 1'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();

    // Full with simultaneous push/pop; 0x100 emerges after 7 further pops
    drive(1'b1, 32'h100, 32'hAAAA_5555, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    repeat (8) step();
    chk("drained_after_full", 64'(bus.count), 64'h0);

    // Wrap-around: 20 push/pop pairs
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(4 * i), ~32'(i), 1'b0, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    repeat (2) step();

    // Flush with simultaneous push; the following push is accepted
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h2000 + 32'(4 * i), 32'h7000 + 32'(i), 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'hBFC0_0380, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, 32'hBFC0_0380, 32'h8765_4321, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    repeat (2) step();

    // Asynchronous reset between clock edges
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h3000 + 32'(4 * i), 32'h9000 + 32'(i), 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_count", 64'(bus.count), 64'h0);
    chk("async_rst_pop_valid", 64'(bus.pop_valid), 64'h0);
    chk("async_rst_pop_pc", 64'(bus.pop_pc), 64'h0);
    chk("async_rst_stall", 64'(bus.stallreq_for_fifo), 64'h0);
    chk("async_rst_ovf", 64'(dut.r_ovf), 64'h0);
    cnt = 0;
    sb.delete();
    exp_stall = 1'b0;
    exp_ovf   = 1'b0;
    step();
    resetn = 1'b1;
    step();

`ifdef INST_FIFO_BYPASS_EN
    drive(1'b1, 32'h200, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
